// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// N_DIG depends on the optional DISPLAY_UNIDAD_EN build macro (adds the "°C" suffix slots).
package display_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_GUION = 7'b0111111;
    localparam logic [6:0] SEG_GRADO = 7'b0011100;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    localparam logic [3:0] ANODOS_OFF = 4'b1111;

`ifdef DISPLAY_UNIDAD_EN
    localparam int N_DIG = 4;
    localparam int IDX_W = 2;
`else
    localparam int N_DIG = 2;
    localparam int IDX_W = 1;
`endif

    typedef enum logic [1:0] {
        SLOT_UNI   = 2'd0,
        SLOT_DEC   = 2'd1,
        SLOT_GRADO = 2'd2,
        SLOT_C     = 2'd3
    } slot_t;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD to active-low 7-segment decoder; values 10..15 show a dash.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_GUION;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_GUION;
        endcase
    end

endmodule

// File: rtl/controlador_display.sv
// Multiplexed common-anode display driver for a two-digit BCD temperature value.
// Define DISPLAY_UNIDAD_EN to scan two extra slots showing the "°C" suffix.
module controlador_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       actualizar,
    input  logic [3:0] decenas,
    input  logic [3:0] unidades,
    output logic [3:0] anodos,
    output logic [6:0] segmentos
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       sh_dec, sh_uni;
    logic [3:0]       dp_dec, dp_uni;
    logic             fin_slot;
    slot_t            slot;
    logic [3:0]       bcd_sel;
    logic [6:0]       seg_dig;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    assign fin_slot = (cnt == CNT_MAX);
    assign slot     = slot_t'(2'(idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (fin_slot) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe on the boundary edge bypasses the shadow so the new slot is never stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dec <= '0;
            sh_uni <= '0;
            dp_dec <= '0;
            dp_uni <= '0;
        end else begin
            if (actualizar) begin
                sh_dec <= decenas;
                sh_uni <= unidades;
            end
            if (fin_slot) begin
                dp_dec <= actualizar ? decenas  : sh_dec;
                dp_uni <= actualizar ? unidades : sh_uni;
            end
        end
    end

    assign bcd_sel = (slot == SLOT_DEC) ? dp_dec : dp_uni;

    decodificador_7seg u_dec (
        .bcd (bcd_sel),
        .seg (seg_dig)
    );

    always_comb begin
        an_nxt  = ANODOS_OFF;
        seg_nxt = seg_dig;
        case (slot)
            SLOT_UNI: an_nxt = 4'b1110;
            SLOT_DEC: begin
                an_nxt = 4'b1101;
                if (dp_dec == 4'd0)
                    seg_nxt = SEG_OFF;
            end
`ifdef DISPLAY_UNIDAD_EN
            SLOT_GRADO: begin
                an_nxt  = 4'b1011;
                seg_nxt = SEG_GRADO;
            end
            SLOT_C: begin
                an_nxt  = 4'b0111;
                seg_nxt = SEG_C;
            end
`endif
            default: begin
                an_nxt  = ANODOS_OFF;
                seg_nxt = SEG_OFF;
            end
        endcase
        if (cnt < BLANK_LIM)
            an_nxt = ANODOS_OFF;
    end

    // Registered outputs give glitch-free pins at a fixed one-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodos    <= ANODOS_OFF;
            segmentos <= SEG_OFF;
        end else begin
            anodos    <= an_nxt;
            segmentos <= seg_nxt;
        end
    end

endmodule
